// File: rtl/int_wb_arbiter.sv
// Round-robin arbiter sharing the integer register-file write port among NUM_REQ
// writeback sources, with one registered output stage and a contention counter.
module int_wb_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*AW-1:0]      req_addr_i,
  input  logic [NUM_REQ*DW-1:0]      req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic                       flush_i,
  output logic                       wr_enable_o,
  output logic [AW-1:0]              wr_addr_o,
  output logic [DW-1:0]              wr_data_o,
  output logic                       grant_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic [15:0]                conflict_cnt_o
);

  localparam int unsigned IdW = $clog2(NUM_REQ);
  localparam logic [IdW:0]   NumReqW = (IdW+1)'(NUM_REQ);
  localparam logic [IdW-1:0] LastIdx = IdW'(NUM_REQ - 1);

  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  logic               wr_enable_q, grant_valid_q;
  logic [AW-1:0]      wr_addr_q;
  logic [DW-1:0]      wr_data_q;
  logic [IdW-1:0]     grant_id_q;
  logic [15:0]        conflict_q;

  logic [NUM_REQ-1:0] grant_oh;
  logic [IdW-1:0]     grant_idx;
  logic               grant_found;
  logic [IdW:0]       scan_sum;
  logic [IdW-1:0]     scan_idx;
  logic [AW-1:0]      win_addr;
  logic [DW-1:0]      win_data;
  logic               multi_valid;

  // Circular scan starting at rr_ptr_q; first valid requester wins.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    scan_sum    = '0;
    scan_idx    = '0;
    if (!flush_i) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_sum = {1'b0, rr_ptr_q} + (IdW+1)'(k);
        if (scan_sum >= NumReqW) begin
          scan_sum = scan_sum - NumReqW;
        end
        scan_idx = scan_sum[IdW-1:0];
        if (!grant_found && req_valid_i[scan_idx]) begin
          grant_found        = 1'b1;
          grant_oh[scan_idx] = 1'b1;
          grant_idx          = scan_idx;
        end
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) begin
        win_addr = req_addr_i[i*AW +: AW];
        win_data = req_data_i[i*DW +: DW];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_found) begin
      rr_ptr_d = (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
    end
  end

  assign multi_valid = ($countones(req_valid_i) > 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      wr_enable_q   <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      conflict_q    <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      grant_valid_q <= grant_found;
      // x0 writes complete the handshake but never reach the register file.
      wr_enable_q   <= grant_found && (win_addr != '0);
      if (grant_found) begin
        wr_addr_q  <= win_addr;
        wr_data_q  <= win_data;
        grant_id_q <= grant_idx;
      end
      if (multi_valid && (conflict_q != 16'hFFFF)) begin
        conflict_q <= conflict_q + 16'd1;
      end
    end
  end

  assign req_ready_o    = grant_oh;
  assign wr_enable_o    = wr_enable_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;
  assign grant_valid_o  = grant_valid_q;
  assign grant_id_o     = grant_id_q;
  assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_int_wb_arbiter.sv
// Directed bench for int_wb_arbiter: reset, rotation, x0 drop, flush, same-address
// ordering through a small register-file model, counter saturation and mid-op reset.
module tb_int_wb_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            flush;
  logic            wr_enable;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic [15:0]     conflict_cnt;

  logic [DW-1:0]   rf [32];

  int errors = 0;
  int checks = 0;

  int_wb_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_addr_i     (req_addr),
    .req_data_i     (req_data),
    .req_ready_o    (req_ready),
    .flush_i        (flush),
    .wr_enable_o    (wr_enable),
    .wr_addr_o      (wr_addr),
    .wr_data_o      (wr_data),
    .grant_valid_o  (grant_valid),
    .grant_id_o     (grant_id),
    .conflict_cnt_o (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model fed by the write port.
  always @(posedge clk) begin
    if (wr_enable) rf[wr_addr] <= wr_data;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    tick(); tick();
    check_eq("rst_wr_enable", 32'(wr_enable), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
    check_eq("rst_wr_data", wr_data, 32'd0);
    check_eq("rst_grant_valid", 32'(grant_valid), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_conflict", 32'(conflict_cnt), 32'd0);
    rst = 1'b0;

    // Single requester.
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 4'b0001;
    settle();
    check_eq("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    settle();
    check_eq("single_ready_idle", 32'(req_ready), 32'h0);
    check_eq("single_we", 32'(wr_enable), 32'd1);
    check_eq("single_addr", 32'(wr_addr), 32'd5);
    check_eq("single_data", wr_data, 32'hDEADBEEF);
    check_eq("single_gv", 32'(grant_valid), 32'd1);
    check_eq("single_gid", 32'(grant_id), 32'd0);
    tick();
    check_eq("single_we_off", 32'(wr_enable), 32'd0);
    check_eq("single_gv_off", 32'(grant_valid), 32'd0);
    check_eq("single_addr_hold", 32'(wr_addr), 32'd5);

    // Round robin from a fresh pointer.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), 32'h100 + 32'(i));
    req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      settle();
      check_eq("rr_ready", 32'(req_ready), 32'(1 << (c % 4)));
      check_eq("rr_conflict", 32'(conflict_cnt), 32'(c));
      tick();
      check_eq("rr_we", 32'(wr_enable), 32'd1);
      check_eq("rr_gid", 32'(grant_id), 32'(c % 4));
      check_eq("rr_addr", 32'(wr_addr), 32'((c % 4) + 1));
      check_eq("rr_data", wr_data, 32'h100 + 32'(c % 4));
    end
    req_valid = '0;

    // x0 write: handshake completes, no register-file write.
    set_req(2, 5'd0, 32'h1234);
    req_valid = 4'b0100;
    settle();
    check_eq("x0_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    check_eq("x0_gv", 32'(grant_valid), 32'd1);
    check_eq("x0_gid", 32'(grant_id), 32'd2);
    check_eq("x0_we", 32'(wr_enable), 32'd0);
    check_eq("x0_data", wr_data, 32'h1234);
    check_eq("x0_conflict", 32'(conflict_cnt), 32'd5);

    // Grant requester 3 so the pointer wraps to 0, then flush under contention.
    set_req(3, 5'd9, 32'h99);
    set_req(1, 5'd11, 32'h11);
    req_valid = 4'b1000;
    tick();
    check_eq("pre_flush_gid", 32'(grant_id), 32'd3);
    req_valid = 4'b1010;
    flush = 1'b1;
    for (int f = 0; f < 3; f++) begin
      settle();
      check_eq("flush_ready", 32'(req_ready), 32'h0);
      check_eq("flush_conflict", 32'(conflict_cnt), 32'(5 + f));
      check_eq("flush_we", 32'(wr_enable), 32'(f == 0));
      tick();
    end
    check_eq("flush_we_end", 32'(wr_enable), 32'd0);
    check_eq("flush_gv_end", 32'(grant_valid), 32'd0);
    check_eq("flush_conflict_end", 32'(conflict_cnt), 32'd8);
    flush = 1'b0;
    settle();
    check_eq("post_flush_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1000;
    check_eq("post_flush_gid1", 32'(grant_id), 32'd1);
    settle();
    check_eq("post_flush_ready3", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    check_eq("post_flush_gid3", 32'(grant_id), 32'd3);
    check_eq("post_flush_conflict", 32'(conflict_cnt), 32'd9);

    // Same destination from two sources: grant order decides the final value.
    set_req(0, 5'd7, 32'hA);
    set_req(1, 5'd7, 32'hB);
    req_valid = 4'b0011;
    settle();
    check_eq("same_ready0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 4'b0010;
    check_eq("same_data_a", wr_data, 32'hA);
    check_eq("same_addr", 32'(wr_addr), 32'd7);
    settle();
    check_eq("same_ready1", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    check_eq("same_data_b", wr_data, 32'hB);
    check_eq("same_rf_a", rf[7], 32'hA);
    tick();
    check_eq("same_rf_b", rf[7], 32'hB);
    check_eq("same_conflict", 32'(conflict_cnt), 32'd10);

    // Saturation: contended and flushed so nothing is granted.
    req_valid = 4'b0011;
    flush = 1'b1;
    repeat (65524) tick();
    check_eq("sat_fffe", 32'(conflict_cnt), 32'hFFFE);
    repeat (3) tick();
    check_eq("sat_ffff", 32'(conflict_cnt), 32'hFFFF);
    check_eq("sat_no_grant", 32'(grant_valid), 32'd0);

    // Reset right after a transfer discards the pending write.
    flush = 1'b0;
    set_req(2, 5'd3, 32'h55);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    rst = 1'b1;
    check_eq("mid_we_before", 32'(wr_enable), 32'd1);
    tick();
    rst = 1'b0;
    check_eq("mid_we", 32'(wr_enable), 32'd0);
    check_eq("mid_gv", 32'(grant_valid), 32'd0);
    check_eq("mid_addr", 32'(wr_addr), 32'd0);
    check_eq("mid_data", wr_data, 32'd0);
    check_eq("mid_gid", 32'(grant_id), 32'd0);
    check_eq("mid_conflict", 32'(conflict_cnt), 32'd0);
    // Pointer is back at 0, so requester 1 beats requester 3.
    req_valid = 4'b1010;
    settle();
    check_eq("mid_rr_ptr", 32'(req_ready), 32'h2);
    req_valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/int_wb_arbiter.md
Name: int_wb_arbiter

Overview:
- Shares the single write port of the 32x32 integer register file among NUM_REQ writeback sources (ALU, MUL, LSU, ...).
- Round-robin arbitration with a valid/ready handshake per requester.
- One registered output stage drives the register-file write port directly; latency is 1 cycle.
- Writes to x0 are accepted and dropped. Flush suppression and a saturating contention counter are provided for perf/debug.

Parameters:
- NUM_REQ, 4, number of writeback requesters (2..8).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*AW  flattened dest addresses; requester i at bits [i*AW +: AW].
- req_data  in  NUM_REQ*DW  flattened write data; requester i at bits [i*DW +: DW].
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- flush  in  1  suppress new grants this cycle.
- wr_enable  out  1  to register-file wr_enable, registered.
- wr_addr  out  AW  to register-file wr_addr, registered.
- wr_data  out  DW  to register-file wr_data, registered.
- grant_valid  out  1  registered: a handshake completed last cycle (includes x0 writes).
- grant_id  out  $clog2(NUM_REQ)  registered index of the last granted requester.
- conflict_cnt  out  16  saturating count of cycles with >1 req_valid.

Behaviour:
- Reset (rst=1 at posedge):
  - wr_enable=0, wr_addr=0, wr_data=0, grant_valid=0, grant_id=0, conflict_cnt=0.
  - rr_ptr=0.
  - rst has priority over every other input.
- Arbitration (combinational, each cycle):
  - If flush=0, the winner is the first i with req_valid[i]=1, scanning circularly from rr_ptr upward (rr_ptr, rr_ptr+1, ... mod NUM_REQ).
  - req_ready has exactly the winner's bit set; all other bits are 0.
  - If no valid request, or flush=1, req_ready=0.
  - req_ready never asserts for a requester whose valid is low.
- Handshake:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - A requester holds valid/addr/data stable until its transfer.
  - Dropping valid before transfer is legal; no state is kept for it.
- Output stage, next posedge after a transfer from requester g:
  - wr_addr <= req_addr[g], wr_data <= req_data[g].
  - wr_enable <= (req_addr[g] != 0).
  - grant_valid <= 1, grant_id <= g.
  - rr_ptr <= (g+1) mod NUM_REQ.
- Cycles with no transfer:
  - wr_enable <= 0, grant_valid <= 0.
  - wr_addr, wr_data and grant_id hold their values.
  - rr_ptr holds.
- Throughput and timing:
  - One write per cycle maximum. The output stage never stalls, because the register file always accepts a write.
  - A write is visible in the register file 2 posedges after the handshake cycle.
- Fairness: any requester holding valid is granted within NUM_REQ cycles, except while flush is high.
- x0 writes: handshake completes and grant_valid=1, but wr_enable=0.
- Same-address requests from different sources: serialized in grant order; the last granted value remains in the register.
- Flush:
  - Blocks new grants only.
  - A write already in the output register still completes (wr_enable is not cancelled).
- conflict_cnt:
  - Increments when popcount(req_valid) >= 2, regardless of flush.
  - Saturates at 16'hFFFF and never wraps.
- Reset mid-operation: pending output write is discarded (wr_enable=0 next cycle); requesters must re-present.

Test Plan:
- Reset, then a single requester: rst for 2 cycles; req_valid=4'b0001, addr=5, data=32'hDEADBEEF for 1 cycle -> req_ready=4'b0001 in that cycle; next cycle wr_enable=1, wr_addr=5, wr_data=DEADBEEF, grant_id=0; following cycle wr_enable=0.
- Round-robin rotation: all 4 valid continuously, distinct addrs 1..4 -> grants in order 0,1,2,3,0; one write per cycle; conflict_cnt increments by 1 each of those cycles.
- x0 drop: requester 2 writes addr=0, data=32'h1234 -> req_ready[2]=1; next cycle grant_valid=1, grant_id=2, wr_enable=0.
- Flush during contention: requesters 1 and 3 valid, flush=1 for 3 cycles -> req_ready=0 and wr_enable=0 throughout, conflict_cnt +3; after flush drops, requester 1 is granted first (rr_ptr=0).
- Same-address collision: requesters 0 and 1 both write addr=7 with data 0xA and 0xB, rr_ptr=0 -> 0xA written, then 0xB; the register-file read of x7 returns 0xB.
- Saturation and mid-op reset: force conflict_cnt to 16'hFFFE, apply 3 contended cycles -> reads 16'hFFFF. Assert rst in the cycle after a transfer -> wr_enable=0 and all outputs at reset values.
